// File: rtl/lab06_pkg.sv
// Shared types and widths for the lab06 stimulus initiator.
//   state_t : FSM states (IDLE, SEND, WAIT)
//   OP_W    : operand / beat width
//   MODE_W  : mode field width
//   RES_W   : datapath reply width
//   FCNT_W  : completed-frame counter width
//   res_t   : signed datapath reply
package lab06_pkg;

    localparam int OP_W   = 4;
    localparam int MODE_W = 2;
    localparam int RES_W  = 6;
    localparam int FCNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

    typedef logic signed [RES_W-1:0] res_t;

endpackage

// File: rtl/lab06_stim_if.sv
// Signal bundle between the lab06 stimulus initiator and its environment.
//   Loader side   : ld_valid, ld_number -> ; <- ld_ready
//   Command side  : start, start_mode -> ; <- busy
//   Datapath side : <- in_valid, in_number, mode ; out_valid, out_result ->
//   Result side   : <- res_valid, res_data, res_timeout, frame_cnt
// modport master : the initiator (lab06_stim)
// modport slave  : whatever surrounds it (loader, datapath, result consumer)
interface lab06_stim_if;
    import lab06_pkg::*;

    logic              ld_valid;
    logic [OP_W-1:0]   ld_number;
    logic              ld_ready;
    logic              start;
    logic [MODE_W-1:0] start_mode;
    logic              busy;
    logic              in_valid;
    logic [OP_W-1:0]   in_number;
    logic [MODE_W-1:0] mode;
    logic              out_valid;
    res_t              out_result;
    logic              res_valid;
    res_t              res_data;
    logic              res_timeout;
    logic [FCNT_W-1:0] frame_cnt;

    modport master (
        input  ld_valid, ld_number, start, start_mode, out_valid, out_result,
        output ld_ready, busy, in_valid, in_number, mode,
               res_valid, res_data, res_timeout, frame_cnt
    );

    modport slave (
        output ld_valid, ld_number, start, start_mode, out_valid, out_result,
        input  ld_ready, busy, in_valid, in_number, mode,
               res_valid, res_data, res_timeout, frame_cnt
    );

endinterface

// File: rtl/lab06_stim_fifo.sv
// Synchronous DEPTH x OP_W operand FIFO with wrap-around pointers.
//   clk, rst : clock, asynchronous active-high reset (flushes pointers/count)
//   push/din : write request and data; dropped when full
//   pop      : read request; head advances, ignored when empty
//   dout     : current head (valid while !empty)
//   full, empty, count : occupancy, all derived from the count register
// DEPTH must be a power of two so the pointers wrap naturally.
module lab06_stim_fifo
    import lab06_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [OP_W-1:0]  din,
    input  logic             pop,
    output logic [OP_W-1:0]  dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [OP_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // Fullness is judged on the pre-pop count, so a push at full is dropped
    // even if a pop happens in the same cycle.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; emptiness is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/lab06_stim.sv
// lab06 stimulus initiator: buffers loaded operands, replays one frame of
// FRAME_LEN beats on in_valid/in_number/mode per accepted start, then waits
// for the datapath reply or a TIMEOUT.
//   clk, rst : clock, asynchronous active-high reset (aborts frame, flushes FIFO)
//   bus      : lab06_stim_if.master (loader, command, datapath, result signals)
// Parameters: FRAME_LEN beats per frame (1..DEPTH), DEPTH FIFO entries
// (power of 2), TIMEOUT maximum WAIT cycles (>= 2).
module lab06_stim
    import lab06_pkg::*;
#(
    parameter int FRAME_LEN = 4,
    parameter int DEPTH     = 8,
    parameter int TIMEOUT   = 100
) (
    input  logic         clk,
    input  logic         rst,
    lab06_stim_if.master bus
);

    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int BEAT_W = $clog2(FRAME_LEN + 1);
    localparam int TMO_W  = $clog2(TIMEOUT);

    state_t            state, state_nxt;
    logic [BEAT_W-1:0] beat_cnt, beat_nxt;
    logic [TMO_W-1:0]  wait_cnt, wait_nxt;
    logic [MODE_W-1:0] mode_lat, mode_lat_nxt;

    logic              in_valid_q, in_valid_nxt;
    logic [OP_W-1:0]   in_number_q, in_number_nxt;
    logic [MODE_W-1:0] mode_q, mode_nxt;
    logic              res_valid_q, res_valid_nxt;
    res_t              res_data_q, res_data_nxt;
    logic              res_timeout_q, res_timeout_nxt;
    logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_nxt;

    logic              fifo_pop;
    logic [OP_W-1:0]   fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    lab06_stim_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.ld_valid),
        .din   (bus.ld_number),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_nxt       = state;
        beat_nxt        = beat_cnt;
        wait_nxt        = wait_cnt;
        mode_lat_nxt    = mode_lat;
        fifo_pop        = 1'b0;
        in_valid_nxt    = 1'b0;
        in_number_nxt   = '0;
        mode_nxt        = '0;
        res_valid_nxt   = 1'b0;
        res_timeout_nxt = 1'b0;
        res_data_nxt    = res_data_q;
        frame_cnt_nxt   = frame_cnt_q;

        case (state)
            IDLE: begin
                // A start without a full frame buffered is silently dropped.
                if (bus.start && (fifo_count >= CNT_W'(FRAME_LEN))) begin
                    state_nxt    = SEND;
                    mode_lat_nxt = bus.start_mode;
                    beat_nxt     = '0;
                end
            end

            SEND: begin
                fifo_pop      = !fifo_empty;
                in_valid_nxt  = 1'b1;
                in_number_nxt = fifo_head;
                mode_nxt      = (beat_cnt == '0) ? mode_lat : '0;
                if (beat_cnt == BEAT_W'(FRAME_LEN - 1)) begin
                    state_nxt = WAIT;
                    wait_nxt  = '0;
                end else begin
                    beat_nxt = beat_cnt + 1'b1;
                end
            end

            WAIT: begin
                // Reply is checked first so it wins over the last timeout cycle.
                if (bus.out_valid) begin
                    res_valid_nxt = 1'b1;
                    res_data_nxt  = bus.out_result;
                    frame_cnt_nxt = frame_cnt_q + 1'b1;
                    state_nxt     = IDLE;
                end else if (wait_cnt == TMO_W'(TIMEOUT - 1)) begin
                    res_timeout_nxt = 1'b1;
                    res_data_nxt    = '0;
                    state_nxt       = IDLE;
                end else begin
                    wait_nxt = wait_cnt + 1'b1;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            beat_cnt      <= '0;
            wait_cnt      <= '0;
            mode_lat      <= '0;
            in_valid_q    <= 1'b0;
            in_number_q   <= '0;
            mode_q        <= '0;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            res_timeout_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            state         <= state_nxt;
            beat_cnt      <= beat_nxt;
            wait_cnt      <= wait_nxt;
            mode_lat      <= mode_lat_nxt;
            in_valid_q    <= in_valid_nxt;
            in_number_q   <= in_number_nxt;
            mode_q        <= mode_nxt;
            res_valid_q   <= res_valid_nxt;
            res_data_q    <= res_data_nxt;
            res_timeout_q <= res_timeout_nxt;
            frame_cnt_q   <= frame_cnt_nxt;
        end
    end

    assign bus.ld_ready    = !fifo_full;
    assign bus.busy        = (state != IDLE);
    assign bus.in_valid    = in_valid_q;
    assign bus.in_number   = in_number_q;
    assign bus.mode        = mode_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_data    = res_data_q;
    assign bus.res_timeout = res_timeout_q;
    assign bus.frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_lab06_stim.sv
// Scoreboard bench for lab06_stim: stimulus pushes expected beats/results
// into queues, a negedge monitor pops and compares whenever the DUT shows
// in_valid or res_valid/res_timeout.
module tb_lab06_stim;
    import lab06_pkg::*;

    localparam int FRAME_LEN = 4;
    localparam int DEPTH     = 8;
    localparam int TIMEOUT   = 100;

    typedef struct {
        bit tmo;
        int data;
    } res_e_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lab06_stim_if bus ();

    lab06_stim #(
        .FRAME_LEN (FRAME_LEN),
        .DEPTH     (DEPTH),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int     n_chk  = 0;
    int     n_pass = 0;
    int     frames = 0;
    int     fifo_m[$];
    int     beat_q[$];
    res_e_t res_q[$];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every presented beat/result against the queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.in_valid) begin
                if (beat_q.size() == 0) begin
                    chk("unexpected_beat", int'({bus.mode, bus.in_number}), -1);
                end else begin
                    chk("beat", int'({bus.mode, bus.in_number}), beat_q.pop_front());
                end
            end
            if (bus.res_valid || bus.res_timeout) begin
                if (res_q.size() == 0) begin
                    chk("unexpected_result", int'($signed(bus.res_data)), 999);
                end else begin
                    res_e_t e;
                    e = res_q.pop_front();
                    chk("res_kind_tmo", int'(bus.res_timeout), int'(e.tmo));
                    chk("res_kind_vld", int'(bus.res_valid), int'(!e.tmo));
                    chk("res_data_mon", int'($signed(bus.res_data)), e.data);
                end
            end
        end
    end

    task automatic push(input int v);
        bus.ld_valid  = 1'b1;
        bus.ld_number = 4'(v);
        if (fifo_m.size() < DEPTH) fifo_m.push_back(v);
        tick();
        bus.ld_valid = 1'b0;
    endtask

    task automatic start_frame(input int m, input bit acc);
        bus.start      = 1'b1;
        bus.start_mode = 2'(m);
        if (acc) begin
            for (int i = 0; i < FRAME_LEN; i++) begin
                int v;
                v = fifo_m.pop_front();
                beat_q.push_back(((i == 0 ? m : 0) << 4) | v);
            end
        end
        tick();
        bus.start = 1'b0;
        chk("busy_after_start", int'(bus.busy), int'(acc));
    endtask

    // Walks the FRAME_LEN beat cycles; optionally pushes a new operand every
    // cycle, or injects a stray start/out_valid on beat 1.
    task automatic beats(input bit push_each, input int base, input bit spur);
        for (int i = 0; i < FRAME_LEN; i++) begin
            if (push_each) begin
                bus.ld_valid  = 1'b1;
                bus.ld_number = 4'(base + i);
                fifo_m.push_back(base + i);
            end
            if (spur && i == 1) begin
                bus.start      = 1'b1;
                bus.start_mode = 2'd3;
                bus.out_valid  = 1'b1;
                bus.out_result = 6'sd7;
            end
            tick();
            bus.ld_valid  = 1'b0;
            bus.start     = 1'b0;
            bus.out_valid = 1'b0;
            chk("beat_valid", int'(bus.in_valid), 1);
        end
    endtask

    task automatic reply(input int d, input int v);
        repeat (d) tick();
        bus.out_valid  = 1'b1;
        bus.out_result = 6'(v);
        res_q.push_back('{tmo: 1'b0, data: v});
        frames++;
        tick();
        bus.out_valid = 1'b0;
        chk("res_valid", int'(bus.res_valid), 1);
        chk("res_timeout_low", int'(bus.res_timeout), 0);
        chk("res_data", int'($signed(bus.res_data)), v);
        chk("frame_cnt", int'(bus.frame_cnt), frames & 255);
        chk("busy_after_res", int'(bus.busy), 0);
        tick();
        chk("res_valid_pulse", int'(bus.res_valid), 0);
    endtask

    task automatic expect_timeout();
        repeat (TIMEOUT - 1) tick();
        chk("timeout_early", int'(bus.res_timeout), 0);
        res_q.push_back('{tmo: 1'b1, data: 0});
        tick();
        chk("timeout", int'(bus.res_timeout), 1);
        chk("timeout_data", int'($signed(bus.res_data)), 0);
        chk("timeout_frame_cnt", int'(bus.frame_cnt), frames & 255);
        chk("busy_after_tmo", int'(bus.busy), 0);
        tick();
        chk("timeout_pulse", int'(bus.res_timeout), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst            = 1'b1;
        bus.ld_valid   = 1'b0;
        bus.ld_number  = '0;
        bus.start      = 1'b0;
        bus.start_mode = '0;
        bus.out_valid  = 1'b0;
        bus.out_result = '0;
        repeat (2) tick();
        chk("rst_ld_ready", int'(bus.ld_ready), 1);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_in_valid", int'(bus.in_valid), 0);
        chk("rst_res_data", int'($signed(bus.res_data)), 0);
        chk("rst_frame_cnt", int'(bus.frame_cnt), 0);
        rst = 1'b0;
        tick();

        // Basic frame: 3,7,1,9 with mode 2, reply -5
        push(3); push(7); push(1); push(9);
        start_frame(2, 1'b1);
        beats(1'b0, 0, 1'b0);
        reply(3, -5);

        // Short FIFO: start ignored, then accepted after 4th operand
        push(2); push(4); push(6);
        start_frame(1, 1'b0);
        repeat (3) tick();
        chk("short_busy", int'(bus.busy), 0);
        chk("short_in_valid", int'(bus.in_valid), 0);
        push(8);
        start_frame(1, 1'b1);
        beats(1'b0, 0, 1'b0);
        reply(0, 12);

        // No reply: timeout
        push(1); push(2); push(3); push(4);
        start_frame(3, 1'b1);
        beats(1'b0, 0, 1'b0);
        expect_timeout();

        // Fill, drop 9th, then push during SEND across pointer wrap
        for (int i = 0; i < DEPTH; i++) push(8 + i);
        chk("full_ld_ready", int'(bus.ld_ready), 0);
        push(1);
        start_frame(0, 1'b1);
        beats(1'b0, 0, 1'b0);
        chk("ld_ready_after_pop", int'(bus.ld_ready), 1);
        reply(1, -32);
        start_frame(1, 1'b1);
        beats(1'b1, 5, 1'b0);
        reply(2, 20);
        start_frame(2, 1'b1);
        beats(1'b0, 0, 1'b0);
        reply(0, 1);

        // Stray start/out_valid during SEND; reply on final WAIT cycle
        push(4); push(3); push(2); push(1);
        start_frame(1, 1'b1);
        beats(1'b0, 0, 1'b1);
        reply(TIMEOUT - 1, -1);

        // Reset mid-SEND after beat 1
        push(11); push(12); push(13); push(14);
        start_frame(2, 1'b1);
        tick();
        chk("pre_rst_beat0", int'(bus.in_valid), 1);
        tick();
        chk("pre_rst_beat1", int'(bus.in_valid), 1);
        #1;
        rst = 1'b1;
        #1;
        beat_q.delete();
        fifo_m.delete();
        frames = 0;
        chk("rst_mid_in_valid", int'(bus.in_valid), 0);
        chk("rst_mid_in_number", int'(bus.in_number), 0);
        chk("rst_mid_mode", int'(bus.mode), 0);
        chk("rst_mid_busy", int'(bus.busy), 0);
        chk("rst_mid_res_data", int'($signed(bus.res_data)), 0);
        chk("rst_mid_frame_cnt", int'(bus.frame_cnt), 0);
        chk("rst_mid_ld_ready", int'(bus.ld_ready), 1);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        push(0); push(15); push(8); push(4);
        start_frame(1, 1'b1);
        beats(1'b0, 0, 1'b0);
        reply(2, 31);

        repeat (3) tick();
        chk("beat_q_drained", beat_q.size(), 0);
        chk("res_q_drained", res_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
